// File: rtl/add_4_if.sv
// rtl/add_4_if.sv - operand/result bundle for the registered ripple-carry adder
interface add_4_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // The operand source drives a/b/cin and observes the registered result
  modport master (
    output a,
    output b,
    output cin,
    input  sum,
    input  cout
  );

  // The adder consumes the operands and drives the registered result
  modport slave (
    input  a,
    input  b,
    input  cin,
    output sum,
    output cout
  );
endinterface

// File: rtl/add_4.sv
// rtl/add_4.sv - registered WIDTH-bit ripple-carry adder with carry-in and carry-out
module add_4 #(
  parameter int WIDTH = 4
) (
  input logic    clk,
  input logic    rst,
  add_4_if.slave bus
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_d;
  logic             cout_q;

  // Ripple chain: carry[0] is cin, each stage is a full adder, carry[WIDTH] is the carry-out
  always_comb begin
    carry    = '0;
    sum_d    = '0;
    carry[0] = bus.cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum_d[i]   = bus.a[i] ^ bus.b[i] ^ carry[i];
      carry[i+1] = (bus.a[i] & bus.b[i]) | (bus.a[i] & carry[i]) | (bus.b[i] & carry[i]);
    end
    cout_d = carry[WIDTH];
  end

  // Result register: captures a fresh sum every edge, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_add_4.sv
// tb/tb_add_4.sv - randomized self-checking bench for add_4 against an arithmetic model
`timescale 1ns/1ps
module tb_add_4;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  add_4_if #(.WIDTH(4)) bus ();

  add_4 #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer addition, split into mod-16 sum and >=16 carry
  function automatic logic [3:0] model_sum(input int a, input int b, input int c);
    int t;
    t = a + b + c;
    return 4'(t % 16);
  endfunction

  function automatic logic model_cout(input int a, input int b, input int c);
    return (a + b + c) >= 16;
  endfunction

  // Drive operands away from the rising edge
  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c);
    @(negedge clk);
    bus.a   = a;
    bus.b   = b;
    bus.cin = c;
  endtask

  task automatic settle_after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.a   = 4'($urandom);
    bus.b   = 4'($urandom);
    bus.cin = 1'($urandom);
    rst     = 1'b1;
    #1;
    total_cnt++;
    if (bus.sum !== 4'h0 || bus.cout !== 1'b0)
      $display("FAIL reset_async got sum=%h cout=%b expected sum=0 cout=0", bus.sum, bus.cout);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.a   = 4'($urandom);
      bus.b   = 4'($urandom);
      bus.cin = 1'($urandom);
      settle_after_edge();
      total_cnt++;
      if (bus.sum !== 4'h0 || bus.cout !== 1'b0)
        $display("FAIL reset_held got sum=%h cout=%b expected sum=0 cout=0", bus.sum, bus.cout);
      else pass_cnt++;
    end
    @(negedge clk);
    rst     = 1'b0;
    bus.a   = 4'h2;
    bus.b   = 4'h0;
    bus.cin = 1'b0;
    settle_after_edge();
    total_cnt++;
    if (bus.sum !== 4'h2 || bus.cout !== 1'b0)
      $display("FAIL reset_release got sum=%h cout=%b expected sum=2 cout=0", bus.sum, bus.cout);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [3:0] va [10] = '{4'h0, 4'h0, 4'h6, 4'h5, 4'h3, 4'h1, 4'hF, 4'h8, 4'hF, 4'h7};
    logic [3:0] vb [10] = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'hF, 4'h8};
    logic       vc [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] es [10] = '{4'h2, 4'h1, 4'h7, 4'h6, 4'h4, 4'h2, 4'h0, 4'h0, 4'hF, 4'hF};
    logic       ec [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(va[i], vb[i], vc[i]);
      settle_after_edge();
      total_cnt++;
      if (bus.sum !== es[i] || bus.cout !== ec[i])
        $display("FAIL directed_%0d a=%h b=%h cin=%b got sum=%h cout=%b expected sum=%h cout=%b",
                 i, va[i], vb[i], vc[i], bus.sum, bus.cout, es[i], ec[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_latency();
    drive(4'h2, 4'h0, 1'b0);
    settle_after_edge();
    @(negedge clk);
    bus.a = 4'h4;
    #2;
    total_cnt++;
    if (bus.sum !== 4'h2 || bus.cout !== 1'b0)
      $display("FAIL latency_hold got sum=%h cout=%b expected sum=2 cout=0", bus.sum, bus.cout);
    else pass_cnt++;
    settle_after_edge();
    total_cnt++;
    if (bus.sum !== 4'h4 || bus.cout !== 1'b0)
      $display("FAIL latency_update got sum=%h cout=%b expected sum=4 cout=0", bus.sum, bus.cout);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [3:0] na;
    logic [3:0] nb;
    logic       nc;
    drive(4'h6, 4'h1, 1'b0);
    settle_after_edge();
    total_cnt++;
    if (bus.sum !== 4'h7 || bus.cout !== 1'b0)
      $display("FAIL mid_pre got sum=%h cout=%b expected sum=7 cout=0", bus.sum, bus.cout);
    else pass_cnt++;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (bus.sum !== 4'h0 || bus.cout !== 1'b0)
      $display("FAIL mid_reset got sum=%h cout=%b expected sum=0 cout=0", bus.sum, bus.cout);
    else pass_cnt++;
    na = 4'($urandom);
    nb = 4'($urandom);
    nc = 1'($urandom);
    bus.a   = na;
    bus.b   = nb;
    bus.cin = nc;
    #1;
    rst = 1'b0;
    settle_after_edge();
    total_cnt++;
    if (bus.sum !== model_sum(na, nb, nc) || bus.cout !== model_cout(na, nb, nc))
      $display("FAIL mid_release got sum=%h cout=%b expected sum=%h cout=%b",
               bus.sum, bus.cout, model_sum(na, nb, nc), model_cout(na, nb, nc));
    else pass_cnt++;
  endtask

  task automatic test_sweep();
    int errs;
    errs = 0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          drive(4'(a), 4'(b), 1'(c));
          settle_after_edge();
          total_cnt++;
          if (bus.sum !== model_sum(a, b, c) || bus.cout !== model_cout(a, b, c)) begin
            errs++;
            if (errs <= 10)
              $display("FAIL sweep a=%h b=%h cin=%0d got sum=%h cout=%b expected sum=%h cout=%b",
                       a, b, c, bus.sum, bus.cout, model_sum(a, b, c), model_cout(a, b, c));
          end else pass_cnt++;
        end
  endtask

  task automatic test_back_to_back_random();
    int qa[$];
    int qb[$];
    int qc[$];
    int ea;
    int eb;
    int ec;
    for (int i = 0; i < 300; i++) begin
      qa.push_back($urandom_range(0, 15));
      qb.push_back($urandom_range(0, 15));
      qc.push_back($urandom_range(0, 1));
      drive(4'(qa[$]), 4'(qb[$]), 1'(qc[$]));
      settle_after_edge();
      ea = qa.pop_front();
      eb = qb.pop_front();
      ec = qc.pop_front();
      total_cnt++;
      if (bus.sum !== model_sum(ea, eb, ec) || bus.cout !== model_cout(ea, eb, ec))
        $display("FAIL random_%0d a=%h b=%h cin=%0d got sum=%h cout=%b expected sum=%h cout=%b",
                 i, ea, eb, ec, bus.sum, bus.cout, model_sum(ea, eb, ec), model_cout(ea, eb, ec));
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    test_reset();
    test_directed();
    test_latency();
    test_reset_mid();
    test_sweep();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/add_4.md
# add_4

Registered 4-bit ripple-carry adder with carry-in and carry-out. It adds two 4-bit unsigned operands and a 1-bit carry-in, and presents the 5-bit result as a 4-bit sum plus carry-out, registered on the clock. It is the arithmetic leaf cell used by the single-cycle CPU datapath exercises and is the building block for wider adders chained through `cin`/`cout`.

## Interface

Parameters:
- `WIDTH`, default 4: operand and sum width. All behaviour below is specified for the default value; any other value scales the same way.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `a`, input, WIDTH: operand A, unsigned.
- `b`, input, WIDTH: operand B, unsigned.
- `cin`, input, 1: carry-in, weight 1.
- `sum`, output, WIDTH: low WIDTH bits of `a + b + cin`. Registered.
- `cout`, output, 1: carry-out, which is bit WIDTH of `a + b + cin`. Registered.

## Operation

- Combinational core: ripple-carry chain of WIDTH 1-bit full adders.
  - Stage i: `s[i] = a[i] ^ b[i] ^ c[i]`.
  - Stage i: `c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i])`.
  - Chain boundaries: `c[0] = cin`, and the carry-out is `c[WIDTH]`.
- Result register: on each rising `clk`, `{cout, sum} <= a + b + cin`, with all operands zero-extended to WIDTH+1 bits.
- Arithmetic is unsigned. There is no signed-overflow flag; `cout` is the only overflow indication.
- Full range at default width:
  - Minimum: 0 + 0 + 0 gives `sum=4'h0`, `cout=0`.
  - Maximum: F + F + 1 = 31 gives `sum=4'hF`, `cout=1`.
- Wrap-around: any result of 16 or more sets `cout=1`, and `sum` holds the result mod 16.
- No enable and no valid/ready handshake. A new result is captured every cycle.
- X/Z on the inputs is not handled specially.

## Timing

- Latency: 1 cycle. Inputs sampled at rising edge N appear on `sum`/`cout` right after edge N and are held until edge N+1.
- Throughput: one addition per cycle.
- Reset value of every output: `sum=0`, `cout=0`.
- Reset assertion: takes effect immediately, with no clock required.
- Reset held: while `rst=1`, outputs stay 0 regardless of `clk` and the inputs.
- Reset release: the first rising edge with `rst=0` captures the current inputs.
- Reset mid-operation: an in-flight result is discarded. Outputs go to 0 asynchronously, and the next post-reset edge captures fresh inputs.
- Input changes between edges have no effect on the outputs until the next rising edge.
- Critical path: `cin` through WIDTH carry stages to the `cout` register D input.

## Test plan

- Reset behaviour:
  - Drive arbitrary inputs with `rst=1`: `sum=0`, `cout=0` with no clock edge.
  - Release reset with `a=4'h2, b=4'h0, cin=0`: after the next edge, `sum=4'h2`, `cout=0`.
- Basic adds, each result checked one edge after the inputs are applied:
  - `a=0, b=1, cin=1`: `sum=2`, `cout=0`.
  - `a=0, b=0, cin=1`: `sum=1`.
  - `a=6, b=1, cin=0`: `sum=7`.
  - `a=5, b=0, cin=1`: `sum=6`.
  - `a=3, b=0, cin=1`: `sum=4`.
  - `a=1, b=0, cin=1`: `sum=2`.
- Carry ripple and wrap-around:
  - `a=F, b=0, cin=1`: `sum=0`, `cout=1`.
  - `a=8, b=8, cin=0`: `sum=0`, `cout=1`.
  - `a=F, b=F, cin=1`: `sum=F`, `cout=1`.
  - `a=7, b=8, cin=0`: `sum=F`, `cout=0`.
- Latency check:
  - Change the inputs mid-cycle (`a=2` → `a=4`, `b=0`, `cin=0`): outputs do not change until the next rising edge, then `sum=4`.
- Reset mid-stream:
  - With `sum=7` held, pulse `rst` between edges: outputs drop to 0 immediately.
  - After release, the next edge loads the current inputs.
- Exhaustive sweep:
  - Run all 512 combinations of `a`, `b`, `cin`, one per cycle.
  - After each edge, check that `{cout, sum}` equals the previous cycle's `a + b + cin`.
